// File: rtl/writeback_queue_if.sv
// ---------------------------------------------------------------------------
// writeback_queue_if
//   Bus bundle for the write-back queue: the eviction handshake from the
//   cache, the refill lookup port and the beat-wide drain port to memory.
//
//   slave  modport : the queue itself
//   master modport : the cache/memory side driving the queue
//
//   enq_*  : eviction offer (valid/ready), block data, line identity, dirty
//   lk_*   : refill lookup key in, hit flag and forwarded block out
//   mem_*  : drain beat offer (valid/ready), address, data, last-beat marker
// ---------------------------------------------------------------------------
interface writeback_queue_if #(
    parameter int BLOCK_SIZE = 8,
    parameter int WORD_SIZE  = 16,
    parameter int BEAT_BYTES = 2,
    parameter int TAG_SIZE   = 4,
    parameter int INDEX_SIZE = 8,
    parameter int ADDR_SIZE  = 16
);
    localparam int BLOCK_W = BLOCK_SIZE * WORD_SIZE;
    localparam int BEAT_DW = 8 * BEAT_BYTES;

    logic                  enq_valid;
    logic                  enq_ready;
    logic [BLOCK_W-1:0]    enq_block;
    logic [TAG_SIZE-1:0]   enq_tag;
    logic [INDEX_SIZE-1:0] enq_index;
    logic                  enq_dirty;

    logic [TAG_SIZE-1:0]   lk_tag;
    logic [INDEX_SIZE-1:0] lk_index;
    logic                  lk_hit;
    logic [BLOCK_W-1:0]    lk_block;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic [BEAT_DW-1:0]    mem_data;
    logic                  mem_last;

    modport slave (
        input  enq_valid, enq_block, enq_tag, enq_index, enq_dirty,
        input  lk_tag, lk_index, mem_ready,
        output enq_ready, lk_hit, lk_block,
        output mem_valid, mem_addr, mem_data, mem_last
    );

    modport master (
        output enq_valid, enq_block, enq_tag, enq_index, enq_dirty,
        output lk_tag, lk_index, mem_ready,
        input  enq_ready, lk_hit, lk_block,
        input  mem_valid, mem_addr, mem_data, mem_last
    );
endinterface

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//   Write-back queue between a set-associative cache and main memory.
//   Dirty evicted blocks are queued in a circular FIFO, clean ones are
//   swallowed. A dirty eviction of a line already queued behind the head
//   overwrites that entry instead of taking a new slot. Queued data is
//   forwarded to refill lookups (youngest match wins). The head entry drains
//   to memory in BEAT_BYTES-wide beats, with mem_last on the final beat.
//   A flush request blocks further enqueues until the queue is empty, then
//   pulses flush_done.
//
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : enq_* / lk_* / mem_* bundle (slave side)
//   flush_req    : one-cycle pulse requesting a full drain
//   flush_done   : one-cycle pulse in the cycle the flush finds count == 0
//   empty, full  : count == 0 / count == DEPTH
//   count        : number of live entries
//
//   ADDR_SIZE is expected to equal TAG_SIZE + INDEX_SIZE + log2(block bytes).
// ---------------------------------------------------------------------------
module writeback_queue #(
    parameter int BLOCK_SIZE = 8,
    parameter int WORD_SIZE  = 16,
    parameter int BEAT_BYTES = 2,
    parameter int DEPTH      = 4,
    parameter int TAG_SIZE   = 4,
    parameter int INDEX_SIZE = 8,
    parameter int ADDR_SIZE  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    writeback_queue_if.slave       bus,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int BLOCK_W     = BLOCK_SIZE * WORD_SIZE;
    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam int BEAT_DW     = 8 * BEAT_BYTES;
    localparam int BEATS       = BLOCK_BYTES / BEAT_BYTES;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int BEAT_CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W       = $clog2(BLOCK_BYTES);

    localparam logic [PTR_W:0]     DEPTH_C     = (PTR_W+1)'(DEPTH);
    localparam logic [BEAT_CW-1:0] LAST_BEAT_C = BEAT_CW'(BEATS - 1);
    localparam logic [OFF_W-1:0]   BEAT_BYTES_C = OFF_W'(BEAT_BYTES);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } flush_state_t;

    // ---------------- state ----------------
    flush_state_t        state_reg, state_next;
    logic [PTR_W-1:0]    head_reg, tail_reg;
    logic [PTR_W:0]      count_reg, count_next;
    logic [BEAT_CW-1:0]  beat_reg;

    logic [BLOCK_W-1:0]    block_mem [DEPTH];
    logic [TAG_SIZE-1:0]   tag_mem   [DEPTH];
    logic [INDEX_SIZE-1:0] index_mem [DEPTH];

    // ---------------- per-entry liveness and key match ----------------
    // age = distance from head; an entry is live when its age is below count.
    logic [PTR_W-1:0] age [DEPTH];
    logic [DEPTH-1:0] live, enq_match, lk_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign age[gi]       = PTR_W'(gi) - head_reg;
            assign live[gi]      = ({1'b0, age[gi]} < count_reg);
            assign enq_match[gi] = live[gi] && (tag_mem[gi] == bus.enq_tag)
                                            && (index_mem[gi] == bus.enq_index);
            assign lk_match[gi]  = live[gi] && (tag_mem[gi] == bus.lk_tag)
                                            && (index_mem[gi] == bus.lk_index);
        end
    endgenerate

    // Youngest (largest age) matching entry for both the enqueue key and the
    // lookup key.
    logic             enq_hit, lk_hit_int;
    logic [PTR_W-1:0] enq_sel, enq_sel_age, lk_sel, lk_sel_age;

    always_comb begin
        enq_hit     = 1'b0;
        enq_sel     = '0;
        enq_sel_age = '0;
        lk_hit_int  = 1'b0;
        lk_sel      = '0;
        lk_sel_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_match[i] && (!enq_hit || age[i] > enq_sel_age)) begin
                enq_hit     = 1'b1;
                enq_sel     = PTR_W'(i);
                enq_sel_age = age[i];
            end
            if (lk_match[i] && (!lk_hit_int || age[i] > lk_sel_age)) begin
                lk_hit_int = 1'b1;
                lk_sel     = PTR_W'(i);
                lk_sel_age = age[i];
            end
        end
    end

    // ---------------- control ----------------
    logic flush_pend;
    logic enq_ready_int, enq_fire, coalesce, push;
    logic mem_valid_int, last_beat, beat_fire, pop;
    logic wr_en;
    logic [PTR_W-1:0] wr_addr;

    assign empty         = (count_reg == '0);
    assign full          = (count_reg == DEPTH_C);
    assign count         = count_reg;

    assign enq_ready_int = (count_reg < DEPTH_C) && !flush_pend;
    assign enq_fire      = bus.enq_valid && enq_ready_int && bus.enq_dirty;
    // The head may be mid-drain, so a head match always takes a fresh slot.
    assign coalesce      = enq_hit && (enq_sel_age != '0);
    assign push          = enq_fire && !coalesce;
    assign wr_en         = enq_fire;
    assign wr_addr       = coalesce ? enq_sel : tail_reg;

    assign mem_valid_int = !empty;
    assign last_beat     = (beat_reg == LAST_BEAT_C);
    assign beat_fire     = mem_valid_int && bus.mem_ready;
    assign pop           = beat_fire && last_beat;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            beat_reg  <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (beat_fire) begin
                if (last_beat) begin
                    beat_reg <= '0;
                    head_reg <= head_reg + 1'b1;
                end else begin
                    beat_reg <= beat_reg + 1'b1;
                end
            end
            count_reg <= count_next;
        end
    end

    // Entry storage needs no reset: liveness is governed by head/count only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            block_mem[wr_addr] <= bus.enq_block;
            tag_mem[wr_addr]   <= bus.enq_tag;
            index_mem[wr_addr] <= bus.enq_index;
        end
    end

    // ---------------- flush FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (flush_req) state_next = S_FLUSH;
            S_FLUSH: if (count_reg == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        flush_pend = 1'b0;
        flush_done = 1'b0;
        case (state_reg)
            S_FLUSH: begin
                flush_pend = 1'b1;
                flush_done = (count_reg == '0);
            end
            default: begin
                flush_pend = 1'b0;
                flush_done = 1'b0;
            end
        endcase
    end

    // ---------------- datapath outputs ----------------
    logic [BLOCK_W-1:0] head_block;
    logic [BEAT_DW-1:0] beat_words [BEATS];
    logic [OFF_W-1:0]   beat_off;

    assign head_block = block_mem[head_reg];

    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign beat_words[gi] = head_block[gi*BEAT_DW +: BEAT_DW];
        end
    endgenerate

    assign beat_off = OFF_W'(beat_reg) * BEAT_BYTES_C;

    assign bus.enq_ready = enq_ready_int;
    assign bus.mem_valid = mem_valid_int;
    assign bus.mem_addr  = mem_valid_int ? {tag_mem[head_reg], index_mem[head_reg], beat_off} : '0;
    assign bus.mem_data  = mem_valid_int ? beat_words[beat_reg] : '0;
    assign bus.mem_last  = mem_valid_int && last_beat;
    assign bus.lk_hit    = lk_hit_int;
    assign bus.lk_block  = lk_hit_int ? block_mem[lk_sel] : '0;

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    writeback_queue_if #(.BEAT_BYTES(2)) bus();
    writeback_queue_if #(.BEAT_BYTES(4)) bus4();

    logic       flush_req, flush_done, empty, full;
    logic [2:0] count;
    logic       flush_req4, flush_done4, empty4, full4;
    logic [2:0] count4;

    int n_cmp = 0;
    int n_err = 0;

    writeback_queue #(.BEAT_BYTES(2), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .flush_req(flush_req), .flush_done(flush_done),
        .empty(empty), .full(full), .count(count)
    );

    writeback_queue #(.BEAT_BYTES(4), .DEPTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4),
        .flush_req(flush_req4), .flush_done(flush_done4),
        .empty(empty4), .full(full4), .count(count4)
    );

    function automatic logic [127:0] mk_block(input logic [15:0] base);
        logic [127:0] b;
        for (int i = 0; i < 8; i++) b[i*16 +: 16] = base + 16'(i);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [3:0] t, input logic [7:0] ix,
                       input logic [127:0] b, input logic d);
        bus.enq_valid = 1'b1;
        bus.enq_tag   = t;
        bus.enq_index = ix;
        bus.enq_block = b;
        bus.enq_dirty = d;
        tick();
        bus.enq_valid = 1'b0;
        bus.enq_dirty = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 80 && !empty; i++) tick();
        n_cmp++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL %s_drain_timeout: empty=%b count=%0d, required empty=1", name, empty, count);
        end
    endtask

    task automatic test_reset();
        bus.enq_valid = 0; bus.enq_dirty = 0; bus.enq_block = '0; bus.enq_tag = '0; bus.enq_index = '0;
        bus.lk_tag = '0; bus.lk_index = '0; bus.mem_ready = 0;
        bus4.enq_valid = 0; bus4.enq_dirty = 0; bus4.enq_block = '0; bus4.enq_tag = '0; bus4.enq_index = '0;
        bus4.lk_tag = '0; bus4.lk_index = '0; bus4.mem_ready = 0;
        flush_req = 0; flush_req4 = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({count, empty, full, bus.enq_ready, bus.mem_valid, bus.mem_last, bus.lk_hit, flush_done}
            !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b rdy=%b mv=%b ml=%b hit=%b fd=%b, required 0 1 0 1 0 0 0 0",
                     count, empty, full, bus.enq_ready, bus.mem_valid, bus.mem_last, bus.lk_hit, flush_done);
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_data, bus.lk_block} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr=%h data=%h lk=%h, required all 0", bus.mem_addr, bus.mem_data, bus.lk_block);
        end
        @(posedge clk); #1;
        reset_n = 1;
        tick();
        n_cmp++;
        if ({count, empty, bus.enq_ready, bus.mem_valid} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: got cnt=%0d e=%b rdy=%b mv=%b, required 0 1 1 0", count, empty, bus.enq_ready, bus.mem_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_drain_a();
        logic [127:0] blk;
        logic [15:0]  exp_addr, exp_data;
        logic         exp_last;
        blk = mk_block(16'h1000);
        bus.mem_ready = 1;
        bus.lk_tag = 4'h3; bus.lk_index = 8'h12;
        bus.enq_valid = 1; bus.enq_dirty = 1; bus.enq_tag = 4'h3; bus.enq_index = 8'h12; bus.enq_block = blk;
        @(negedge clk);
        n_cmp++;
        if ({bus.lk_hit, bus.mem_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL drain_same_cycle: got hit=%b mv=%b, required 0 0", bus.lk_hit, bus.mem_valid);
        end
        tick();
        bus.enq_valid = 0; bus.enq_dirty = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_addr = 16'h3120 + 16'(2 * k);
            exp_data = 16'h1000 + 16'(k);
            exp_last = (k == 7);
            n_cmp++;
            if ({bus.mem_valid, bus.mem_addr, bus.mem_data, bus.mem_last} !== {1'b1, exp_addr, exp_data, exp_last}) begin
                n_err++;
                $display("FAIL drain_beat%0d: got v=%b a=%h d=%h l=%b, required v=1 a=%h d=%h l=%b",
                         k, bus.mem_valid, bus.mem_addr, bus.mem_data, bus.mem_last, exp_addr, exp_data, exp_last);
            end
            if (k == 7) begin
                n_cmp++;
                if ({bus.lk_hit, bus.lk_block} !== {1'b1, blk}) begin
                    n_err++;
                    $display("FAIL lookup_last_beat: got hit=%b blk=%h, required 1 %h", bus.lk_hit, bus.lk_block, blk);
                end
            end
            tick();
        end
        n_cmp++;
        if ({count, empty, bus.mem_valid, bus.lk_hit} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL drain_end: got cnt=%0d e=%b mv=%b hit=%b, required 0 1 0 0", count, empty, bus.mem_valid, bus.lk_hit);
        end
        $display("test_drain_a done");
    endtask

    task automatic test_beat4();
        logic [15:0] exp_addr;
        logic [31:0] exp_data;
        bus4.mem_ready = 1;
        bus4.enq_valid = 1; bus4.enq_dirty = 1; bus4.enq_tag = 4'h3; bus4.enq_index = 8'h12;
        bus4.enq_block = mk_block(16'h1000);
        tick();
        bus4.enq_valid = 0; bus4.enq_dirty = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_addr = 16'h3120 + 16'(4 * k);
            exp_data = {16'h1000 + 16'(2 * k + 1), 16'h1000 + 16'(2 * k)};
            n_cmp++;
            if ({bus4.mem_addr, bus4.mem_data, bus4.mem_last} !== {exp_addr, exp_data, (k == 3)}) begin
                n_err++;
                $display("FAIL beat4_%0d: got a=%h d=%h l=%b, required a=%h d=%h l=%b",
                         k, bus4.mem_addr, bus4.mem_data, bus4.mem_last, exp_addr, exp_data, (k == 3));
            end
            tick();
        end
        n_cmp++;
        if (empty4 !== 1'b1) begin
            n_err++;
            $display("FAIL beat4_end: got empty=%b, required 1", empty4);
        end
        $display("test_beat4 done");
    endtask

    task automatic test_full();
        int beat;
        bus.mem_ready = 0;
        enq(4'h1, 8'h20, mk_block(16'h2000), 1);
        enq(4'h2, 8'h21, mk_block(16'h2100), 1);
        enq(4'h7, 8'h27, mk_block(16'h2700), 0);
        n_cmp++;
        if (count !== 3'd2) begin
            n_err++;
            $display("FAIL clean_discard: got count=%0d, required 2", count);
        end
        enq(4'h3, 8'h22, mk_block(16'h2200), 1);
        enq(4'h4, 8'h23, mk_block(16'h2300), 1);
        bus.lk_tag = 4'h7; bus.lk_index = 8'h27;
        #1;
        n_cmp++;
        if ({full, bus.enq_ready, count, bus.lk_hit} !== {1'b1, 1'b0, 3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL full_flags: got full=%b rdy=%b cnt=%0d hit=%b, required 1 0 4 0", full, bus.enq_ready, count, bus.lk_hit);
        end
        enq(4'h5, 8'h25, mk_block(16'h2500), 1);
        n_cmp++;
        if (count !== 3'd4) begin
            n_err++;
            $display("FAIL full_reject: got count=%0d, required 4", count);
        end
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_ready = (c % 2 == 0);
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_addr, bus.mem_data} !== {16'h1200 + 16'(2 * beat), 16'h2000 + 16'(beat)}) begin
                n_err++;
                $display("FAIL stall_c%0d: got a=%h d=%h, required a=%h d=%h", c, bus.mem_addr, bus.mem_data,
                         16'h1200 + 16'(2 * beat), 16'h2000 + 16'(beat));
            end
            tick();
            if (c % 2 == 0) beat++;
        end
        bus.mem_ready = 1;
        wait_empty("full");
        $display("test_full done");
    endtask

    task automatic test_coalesce();
        logic found;
        bus.mem_ready = 1;
        enq(4'h3, 8'h12, mk_block(16'h1000), 1);
        enq(4'h5, 8'h34, mk_block(16'h2000), 1);
        enq(4'h3, 8'h12, mk_block(16'h3000), 1);
        bus.lk_tag = 4'h3; bus.lk_index = 8'h12;
        @(negedge clk);
        n_cmp++;
        if ({count, bus.lk_hit, bus.lk_block} !== {3'd3, 1'b1, mk_block(16'h3000)}) begin
            n_err++;
            $display("FAIL newer_entry: got cnt=%0d hit=%b blk=%h, required 3 1 %h", count, bus.lk_hit, bus.lk_block, mk_block(16'h3000));
        end
        enq(4'h3, 8'h12, mk_block(16'h4000), 1);
        @(negedge clk);
        n_cmp++;
        if ({count, bus.lk_hit, bus.lk_block} !== {3'd3, 1'b1, mk_block(16'h4000)}) begin
            n_err++;
            $display("FAIL coalesce: got cnt=%0d hit=%b blk=%h, required 3 1 %h", count, bus.lk_hit, bus.lk_block, mk_block(16'h4000));
        end
        bus.lk_tag = 4'h9; bus.lk_index = 8'h99;
        #1;
        n_cmp++;
        if ({bus.lk_hit, bus.lk_block} !== {1'b0, 128'h0}) begin
            n_err++;
            $display("FAIL lookup_miss: got hit=%b blk=%h, required 0 0", bus.lk_hit, bus.lk_block);
        end
        bus.lk_tag = 4'h5; bus.lk_index = 8'h34;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_valid && bus.mem_last && bus.mem_addr[15:4] == 12'h534) found = 1;
        end
        n_cmp++;
        if (!found || {bus.lk_hit, bus.lk_block} !== {1'b1, mk_block(16'h2000)}) begin
            n_err++;
            $display("FAIL head_last_lookup: got found=%b hit=%b blk=%h, required 1 1 %h", found, bus.lk_hit, bus.lk_block, mk_block(16'h2000));
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.lk_hit, count, bus.mem_addr, bus.mem_data} !== {1'b0, 3'd1, 16'h3120, 16'h4000}) begin
            n_err++;
            $display("FAIL after_b: got hit=%b cnt=%0d a=%h d=%h, required 0 1 3120 4000", bus.lk_hit, count, bus.mem_addr, bus.mem_data);
        end
        wait_empty("coalesce");
        $display("test_coalesce done");
    endtask

    task automatic test_back_to_back();
        logic found;
        bus.mem_ready = 1;
        enq(4'h3, 8'h12, mk_block(16'h1000), 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_last) found = 1;
        end
        enq(4'h5, 8'h34, mk_block(16'h2000), 1);
        n_cmp++;
        if ({found, count, bus.mem_addr, bus.mem_data} !== {1'b1, 3'd1, 16'h5340, 16'h2000}) begin
            n_err++;
            $display("FAIL back_to_back: got found=%b cnt=%0d a=%h d=%h, required 1 1 5340 2000", found, count, bus.mem_addr, bus.mem_data);
        end
        wait_empty("b2b");
        $display("test_back_to_back done");
    endtask

    task automatic test_flush();
        logic [2:0] exp_cnt;
        bus.mem_ready = 0;
        enq(4'h1, 8'h40, mk_block(16'h5000), 1);
        enq(4'h2, 8'h41, mk_block(16'h6000), 1);
        flush_req = 1;
        tick();
        flush_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({bus.enq_ready, flush_done, count} !== {1'b0, 1'b0, 3'd2}) begin
            n_err++;
            $display("FAIL flush_start: got rdy=%b fd=%b cnt=%0d, required 0 0 2", bus.enq_ready, flush_done, count);
        end
        bus.mem_ready = 1;
        bus.enq_valid = 1; bus.enq_dirty = 1; bus.enq_tag = 4'hA; bus.enq_index = 8'h4A;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 4) begin bus.enq_valid = 0; bus.enq_dirty = 0; end
            exp_cnt = (c < 8) ? 3'd2 : ((c < 16) ? 3'd1 : 3'd0);
            n_cmp++;
            if ({count, flush_done, bus.enq_ready} !== {exp_cnt, (c == 16), 1'b0}) begin
                n_err++;
                $display("FAIL flush_c%0d: got cnt=%0d fd=%b rdy=%b, required %0d %b 0", c, count, flush_done, bus.enq_ready, exp_cnt, (c == 16));
            end
        end
        tick();
        n_cmp++;
        if ({flush_done, bus.enq_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL flush_after: got fd=%b rdy=%b, required 0 1", flush_done, bus.enq_ready);
        end
        flush_req = 1;
        tick();
        flush_req = 0;
        n_cmp++;
        if (flush_done !== 1'b1) begin
            n_err++;
            $display("FAIL flush_empty: got fd=%b, required 1", flush_done);
        end
        tick();
        n_cmp++;
        if (flush_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_empty_pulse: got fd=%b, required 0", flush_done);
        end
        $display("test_flush done");
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_ready = 1;
        enq(4'h1, 8'h50, mk_block(16'h7000), 1);
        enq(4'h2, 8'h51, mk_block(16'h7100), 1);
        tick();
        n_cmp++;
        if ({bus.mem_valid, count} !== {1'b1, 3'd2}) begin
            n_err++;
            $display("FAIL pre_reset: got mv=%b cnt=%0d, required 1 2", bus.mem_valid, count);
        end
        reset_n = 0;
        #1;
        n_cmp++;
        if ({bus.mem_valid, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got mv=%b cnt=%0d e=%b, required 0 0 1", bus.mem_valid, count, empty);
        end
        @(negedge clk);
        reset_n = 1;
        tick();
        n_cmp++;
        if ({bus.mem_valid, count} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL post_reset: got mv=%b cnt=%0d, required 0 0", bus.mem_valid, count);
        end
        $display("test_reset_mid_drain done");
    endtask

    initial begin
        test_reset();
        test_drain_a();
        test_beat4();
        test_full();
        test_coalesce();
        test_back_to_back();
        test_flush();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
